rotate_kick_engine: RTL and testbench
=====================================

// Module: rotate_kick_engine
// PURPOSE
//  Multi-cycle tetromino rotation unit with SRS wall kicks, CW/CCW direction and a collision-check handshake.
//  Sits between the game FSM (issues start) and the board collision checker (answers candidate queries).
//  Returns the first collision-free candidate, or the unchanged piece on failure.
// PARAMETERS
//  NUM_KICKS  5  kick offsets tried per rotation (1..5); entry 0 is always (0,0)
//  COORD_W    6  width of signed x/y coordinate fields used in offset arithmetic
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        request rotation; sampled only in IDLE
//  dir          in   2        2'b00 CW, 2'b01 CCW, 2'b10 180 (ROT_180_EN only); 2'b11 reserved
//  t_in         in   tetromino_ctrl  piece to rotate; captured on accepted start
//  chk_req      out  1        candidate valid, held until chk_ack
//  chk_t        out  tetromino_ctrl  candidate piece; stable while chk_req=1
//  chk_ack      in   1        checker result valid this cycle
//  chk_collide  in   1        1 = candidate collides/out of bounds; valid with chk_ack
//  t_out        out  tetromino_ctrl  result piece; valid while done=1, then held
//  busy         out  1        1 from accepted start until done
//  done         out  1        one-cycle completion pulse
//  success      out  1        qualifies done: 1 = rotated, 0 = rejected
// BEHAVIOUR
//  Reset: FSM=IDLE, chk_req=0, busy=0, done=0, success=0, t_out/chk_t all-zero (idx=TETROMINO_EMPTY), kick index k=0.
//  States: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//  IDLE: start=1 latches t_in and dir, k=0, busy=1, -> REQ next cycle. start while busy is ignored (no queue).
//  REQ: chk_req=1, chk_t = latched piece with rotation' and coordinate + kick[idx][rot][dir][k].
//   rotation' = rotation+1 (CW), -1 (CCW), +2 (180), 2-bit wrap: 3 CW -> 0, 0 CCW -> 3.
//  chk_ack may arrive the same cycle as chk_req or later; chk_req stays high, chk_t frozen until ack.
//  ack & !collide: t_out=chk_t, success=1 -> DONE. ack & collide: k++; k==NUM_KICKS -> DONE with t_out=latched t_in,
//   success=0; else new candidate presented the next cycle (chk_req drops for exactly one cycle between candidates).
//  DONE: done=1, busy=0 for one cycle -> IDLE. Min latency start->done: 3 cycles (ack same cycle as req).
//  O-piece: no checker query; rotation' applied, coordinate unchanged, success=1, done 2 cycles after start.
//  dir=2'b11 or 180 without ROT_180_EN: done with success=0, t_out=t_in, no query.
//  Offsets: signed COORD_W, y-down convention, sign-extended before add; no saturation (checker rejects out-of-board).
//  I-piece uses the I kick table; J/L/S/T/Z share the JLSTZ table.
//  Reset mid-operation: immediate return to IDLE, chk_req drops, no done pulse emitted.
//  Shape rows (tetromino.data) passed through unchanged; only rotation/coordinate are modified.
// CONFIGURATION
//  ROT_180_EN defined: dir=2'b10 performs 180 rotation using only kick entry 0 (single query, no further kicks).
//  ROT_180_EN undefined: dir=2'b10 treated as reserved (immediate reject); no 180 logic synthesised.
// STRUCTURE
//  Shared package (GLOBAL.sv): kick_offset_t {signed dx, dy}, rot_dir_e, SRS JLSTZ and I kick tables
//   indexed [from_rot][dir][k], NUM_KICKS_MAX=5 constant.
//  Sub-module: rotate_kick_table -- combinational lookup (idx, from_rot, dir, k) -> kick_offset_t.
//  Top: FSM, latched piece/dir, kick counter, candidate register.
// TESTING
//  T-piece rot 0 at (5,5), CW, checker acks no-collide on first query -> rot 1, (5,5), success=1, done at cycle 3.
//  T-piece rot 0 at (5,5), CCW, first two queries collide -> third candidate rot 3 with JLSTZ 0->3 k=2 offset, success=1.
//  I-piece rot 3, CW, all NUM_KICKS queries collide -> exactly 5 chk_req handshakes, t_out==t_in, success=0.
//  O-piece rot 3, CW -> rot 0, no chk_req asserted, success=1, done 2 cycles after start.
//  Checker delays ack 4 cycles -> chk_t stable throughout; start pulsed while busy -> ignored, single done.
//  rst asserted while waiting on ack -> chk_req/busy low next edge, no done; 180 on T rot 1 -> rot 3 iff ROT_180_EN.

Source files
------------

// File: rtl/rotate_kick_engine_pkg.sv
// ---------------------------------------------------------------------------
// rotate_kick_engine_pkg
// Shared types and constants for the SRS rotation / wall-kick engine:
//   tetromino_idx_e  piece identifier (TETROMINO_EMPTY = all-zero)
//   rot_dir_e        rotation direction code (CW, CCW, 180, reserved)
//   kick_offset_t    signed (dx, dy) kick offset, y grows downwards
//   tetromino_ctrl   piece descriptor: idx, rotation, x, y, shape rows
//   engine_state_e   rotation FSM states
//   SRS kick tables  JLSTZ_* and I_* indexed [from_rot][dir][k]
// Optional feature macro: ROT_180_EN (enables the 180-degree step code).
// ---------------------------------------------------------------------------
package rotate_kick_engine_pkg;

  localparam int COORD_W_PKG   = 6;
  localparam int NUM_KICKS_MAX = 5;
  localparam int KICK_W        = 3;

  typedef enum logic [2:0] {
    TETROMINO_EMPTY = 3'd0,
    TETROMINO_I     = 3'd1,
    TETROMINO_J     = 3'd2,
    TETROMINO_L     = 3'd3,
    TETROMINO_O     = 3'd4,
    TETROMINO_S     = 3'd5,
    TETROMINO_T     = 3'd6,
    TETROMINO_Z     = 3'd7
  } tetromino_idx_e;

  typedef enum logic [1:0] {
    DIR_CW   = 2'b00,
    DIR_CCW  = 2'b01,
    DIR_180  = 2'b10,
    DIR_RSVD = 2'b11
  } rot_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } engine_state_e;

  typedef struct packed {
    logic signed [KICK_W-1:0] dx;
    logic signed [KICK_W-1:0] dy;
  } kick_offset_t;

  typedef struct packed {
    tetromino_idx_e                 idx;
    logic [1:0]                     rotation;
    logic signed [COORD_W_PKG-1:0]  x;
    logic signed [COORD_W_PKG-1:0]  y;
    logic [15:0]                    data;
  } tetromino_ctrl;

  // SRS tables with dy negated relative to the usual y-up listing.
  // Second index: 0 = CW, 1 = CCW.
  localparam logic signed [KICK_W-1:0] JLSTZ_DX [4][2][NUM_KICKS_MAX] = '{
    '{'{3'sd0, -3'sd1, -3'sd1, 3'sd0, -3'sd1}, '{3'sd0,  3'sd1,  3'sd1, 3'sd0,  3'sd1}},
    '{'{3'sd0,  3'sd1,  3'sd1, 3'sd0,  3'sd1}, '{3'sd0,  3'sd1,  3'sd1, 3'sd0,  3'sd1}},
    '{'{3'sd0,  3'sd1,  3'sd1, 3'sd0,  3'sd1}, '{3'sd0, -3'sd1, -3'sd1, 3'sd0, -3'sd1}},
    '{'{3'sd0, -3'sd1, -3'sd1, 3'sd0, -3'sd1}, '{3'sd0, -3'sd1, -3'sd1, 3'sd0, -3'sd1}}
  };

  localparam logic signed [KICK_W-1:0] JLSTZ_DY [4][2][NUM_KICKS_MAX] = '{
    '{'{3'sd0, 3'sd0, -3'sd1,  3'sd2,  3'sd2}, '{3'sd0, 3'sd0, -3'sd1,  3'sd2,  3'sd2}},
    '{'{3'sd0, 3'sd0,  3'sd1, -3'sd2, -3'sd2}, '{3'sd0, 3'sd0,  3'sd1, -3'sd2, -3'sd2}},
    '{'{3'sd0, 3'sd0, -3'sd1,  3'sd2,  3'sd2}, '{3'sd0, 3'sd0, -3'sd1,  3'sd2,  3'sd2}},
    '{'{3'sd0, 3'sd0,  3'sd1, -3'sd2, -3'sd2}, '{3'sd0, 3'sd0,  3'sd1, -3'sd2, -3'sd2}}
  };

  localparam logic signed [KICK_W-1:0] I_DX [4][2][NUM_KICKS_MAX] = '{
    '{'{3'sd0, -3'sd2,  3'sd1, -3'sd2,  3'sd1}, '{3'sd0, -3'sd1,  3'sd2, -3'sd1,  3'sd2}},
    '{'{3'sd0, -3'sd1,  3'sd2, -3'sd1,  3'sd2}, '{3'sd0,  3'sd2, -3'sd1,  3'sd2, -3'sd1}},
    '{'{3'sd0,  3'sd2, -3'sd1,  3'sd2, -3'sd1}, '{3'sd0,  3'sd1, -3'sd2,  3'sd1, -3'sd2}},
    '{'{3'sd0,  3'sd1, -3'sd2,  3'sd1, -3'sd2}, '{3'sd0, -3'sd2,  3'sd1, -3'sd2,  3'sd1}}
  };

  localparam logic signed [KICK_W-1:0] I_DY [4][2][NUM_KICKS_MAX] = '{
    '{'{3'sd0, 3'sd0, 3'sd0,  3'sd1, -3'sd2}, '{3'sd0, 3'sd0, 3'sd0, -3'sd2,  3'sd1}},
    '{'{3'sd0, 3'sd0, 3'sd0, -3'sd2,  3'sd1}, '{3'sd0, 3'sd0, 3'sd0, -3'sd1,  3'sd2}},
    '{'{3'sd0, 3'sd0, 3'sd0, -3'sd1,  3'sd2}, '{3'sd0, 3'sd0, 3'sd0,  3'sd2, -3'sd1}},
    '{'{3'sd0, 3'sd0, 3'sd0,  3'sd2, -3'sd1}, '{3'sd0, 3'sd0, 3'sd0,  3'sd1, -3'sd2}}
  };

  // Amount added to the 2-bit rotation field (mod 4) for a direction.
  function automatic logic [1:0] rot_step(input rot_dir_e d);
    logic [1:0] step;
    case (d)
      DIR_CW:  step = 2'd1;
      DIR_CCW: step = 2'd3;
`ifdef ROT_180_EN
      DIR_180: step = 2'd2;
`endif
      default: step = 2'd0;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/rotate_kick_table.sv
// ---------------------------------------------------------------------------
// rotate_kick_table
// Combinational SRS kick lookup.
//   idx       in  piece identifier (I uses the I table, J/L/S/T/Z share JLSTZ)
//   from_rot  in  rotation state before the move
//   dir       in  rotation direction
//   k         in  kick index (entry 0 is always (0,0))
//   offset    out signed (dx, dy) kick, y-down
// O / empty pieces, 180 and reserved directions always yield (0,0).
// ---------------------------------------------------------------------------
module rotate_kick_table
  import rotate_kick_engine_pkg::*;
(
  input  tetromino_idx_e idx,
  input  logic [1:0]     from_rot,
  input  rot_dir_e       dir,
  input  logic [2:0]     k,
  output kick_offset_t   offset
);

  // Table select: only CW/CCW moves of kicking pieces have non-zero offsets.
  always_comb begin
    offset = '0;
    if (((dir == DIR_CW) || (dir == DIR_CCW)) && (k < 3'(NUM_KICKS_MAX))) begin
      case (idx)
        TETROMINO_I: begin
          offset.dx = I_DX[from_rot][dir[0]][k];
          offset.dy = I_DY[from_rot][dir[0]][k];
        end
        TETROMINO_J, TETROMINO_L, TETROMINO_S, TETROMINO_T, TETROMINO_Z: begin
          offset.dx = JLSTZ_DX[from_rot][dir[0]][k];
          offset.dy = JLSTZ_DY[from_rot][dir[0]][k];
        end
        default: offset = '0;
      endcase
    end else begin
      offset = '0;
    end
  end

endmodule

// File: rtl/rotate_kick_engine.sv
// ---------------------------------------------------------------------------
// rotate_kick_engine
// Multi-cycle tetromino rotation with SRS wall kicks. On start the piece and
// direction are latched; candidates are offered to an external collision
// checker one at a time until one fits or the kick list is exhausted.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, dir, t_in     rotation request (sampled only when idle)
//   chk_req, chk_t       candidate handshake towards the checker
//   chk_ack, chk_collide checker answer
//   t_out, success, done result (done is a one-cycle pulse)
//   busy                 high from accepted start until done
// Optional feature macro: ROT_180_EN (dir=2'b10 performs a single-query
// 180-degree rotation; otherwise dir=2'b10 is rejected like 2'b11).
// ---------------------------------------------------------------------------
module rotate_kick_engine
  import rotate_kick_engine_pkg::*;
#(
  parameter int NUM_KICKS = 5,
  parameter int COORD_W   = COORD_W_PKG
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    dir,
  input  tetromino_ctrl t_in,
  output logic          chk_req,
  output tetromino_ctrl chk_t,
  input  logic          chk_ack,
  input  logic          chk_collide,
  output tetromino_ctrl t_out,
  output logic          busy,
  output logic          done,
  output logic          success
);

  localparam logic [2:0] LAST_K = 3'(NUM_KICKS - 1);

  engine_state_e state_q, state_d;
  tetromino_ctrl piece_q, piece_d;
  rot_dir_e      dir_q, dir_d;
  logic [2:0]    k_q, k_d;
  logic          chk_req_q, chk_req_d;
  tetromino_ctrl chk_t_q, chk_t_d;
  tetromino_ctrl t_out_q, t_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          success_q, success_d;

  kick_offset_t  kick_s;
  tetromino_ctrl cand_s;
  logic          dir_ok_s;
  logic          last_s;

  rotate_kick_table u_table (
    .idx      (piece_q.idx),
    .from_rot (piece_q.rotation),
    .dir      (dir_q),
    .k        (k_q),
    .offset   (kick_s)
  );

  // Candidate = latched piece, rotated, shifted by the sign-extended kick.
  always_comb begin
    cand_s          = piece_q;
    cand_s.rotation = piece_q.rotation + rot_step(dir_q);
    cand_s.x        = piece_q.x + {{(COORD_W-KICK_W){kick_s.dx[KICK_W-1]}}, kick_s.dx};
    cand_s.y        = piece_q.y + {{(COORD_W-KICK_W){kick_s.dy[KICK_W-1]}}, kick_s.dy};
  end

  // Direction legality and end-of-kick-list detection (180 gets one try).
  always_comb begin
`ifdef ROT_180_EN
    dir_ok_s = (dir_q != DIR_RSVD);
    last_s   = (k_q == LAST_K) || (dir_q == DIR_180);
`else
    dir_ok_s = (dir_q == DIR_CW) || (dir_q == DIR_CCW);
    last_s   = (k_q == LAST_K);
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    piece_d   = piece_q;
    dir_d     = dir_q;
    k_d       = k_q;
    chk_req_d = chk_req_q;
    chk_t_d   = chk_t_q;
    t_out_d   = t_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    success_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          piece_d = t_in;
          dir_d   = rot_dir_e'(dir);
          k_d     = 3'd0;
          busy_d  = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!dir_ok_s) begin
          t_out_d = piece_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else if (piece_q.idx == TETROMINO_O) begin
          // O never collides after rotation: rotate in place, no query.
          t_out_d   = cand_s;
          success_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          chk_req_d = 1'b1;
          chk_t_d   = cand_s;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (chk_ack) begin
          chk_req_d = 1'b0;
          if (!chk_collide) begin
            t_out_d   = chk_t_q;
            success_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_DONE;
          end else if (last_s) begin
            t_out_d = piece_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            // Passing through REQ gives the one-cycle chk_req gap.
            k_d     = k_q + 3'd1;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      piece_q   <= '0;
      dir_q     <= DIR_CW;
      k_q       <= 3'd0;
      chk_req_q <= 1'b0;
      chk_t_q   <= '0;
      t_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      piece_q   <= piece_d;
      dir_q     <= dir_d;
      k_q       <= k_d;
      chk_req_q <= chk_req_d;
      chk_t_q   <= chk_t_d;
      t_out_q   <= t_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      success_q <= success_d;
    end
  end

  assign chk_req = chk_req_q;
  assign chk_t   = chk_t_q;
  assign t_out   = t_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign success = success_q;

endmodule

// File: tb/tb_rotate_kick_engine.sv
// ---------------------------------------------------------------------------
// tb_rotate_kick_engine
// Scoreboard bench: each directed operation pushes its expected checker
// candidates and its expected result into queues; a checker-model process
// answers chk_req and compares candidates, a done monitor compares results.
// ---------------------------------------------------------------------------
module tb_rotate_kick_engine;
  import rotate_kick_engine_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    dir;
  tetromino_ctrl t_in;
  logic          chk_req;
  tetromino_ctrl chk_t;
  logic          chk_ack;
  logic          chk_collide;
  tetromino_ctrl t_out;
  logic          busy;
  logic          done;
  logic          success;

  typedef struct {
    tetromino_ctrl t;
    logic          success;
    int            cycle;
  } exp_done_t;

  typedef struct {
    tetromino_ctrl t;
    logic          collide;
    int            delay;
  } exp_cand_t;

  exp_done_t done_q[$];
  exp_cand_t cand_q[$];
  int        checks    = 0;
  int        failures  = 0;
  int        cyc       = 0;
  logic      rst_event = 1'b0;

  localparam logic [15:0] D_T = 16'h0E40;
  localparam logic [15:0] D_I = 16'h0F00;
  localparam logic [15:0] D_O = 16'h0660;
  localparam logic [15:0] D_Z = 16'h0C60;
  localparam logic [15:0] D_L = 16'h02E0;
  localparam logic [15:0] D_J = 16'h08E0;
  localparam logic [15:0] D_S = 16'h06C0;

  rotate_kick_engine dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dir         (dir),
    .t_in        (t_in),
    .chk_req     (chk_req),
    .chk_t       (chk_t),
    .chk_ack     (chk_ack),
    .chk_collide (chk_collide),
    .t_out       (t_out),
    .busy        (busy),
    .done        (done),
    .success     (success)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic tetromino_ctrl mk(input tetromino_idx_e idx, input logic [1:0] rot,
                                       input int x, input int y, input logic [15:0] data);
    tetromino_ctrl p;
    p.idx      = idx;
    p.rotation = rot;
    p.x        = 6'(x);
    p.y        = 6'(y);
    p.data     = data;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic add_cand(input tetromino_ctrl t, input logic collide, input int delay);
    exp_cand_t c;
    c.t       = t;
    c.collide = collide;
    c.delay   = delay;
    cand_q.push_back(c);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (((done_q.size() != 0) || (cand_q.size() != 0)) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, 64'(n < 100), 64'd1);
    done_q.delete();
    cand_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic run_op(input string name, input tetromino_ctrl p, input logic [1:0] d,
                        input tetromino_ctrl exp_t, input logic exp_s, input int lat);
    exp_done_t e;
    @(negedge clk);
    e.t       = exp_t;
    e.success = exp_s;
    e.cycle   = cyc + lat;
    done_q.push_back(e);
    t_in  = p;
    dir   = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(name);
  endtask

  // Checker model: compares each candidate, holds it for its delay, answers.
  initial begin : checker_model
    exp_cand_t c;
    bit        aborted;
    chk_ack     = 1'b0;
    chk_collide = 1'b0;
    forever begin
      @(negedge clk);
      chk_ack     = 1'b0;
      chk_collide = 1'b0;
      if (!rst && chk_req) begin
        if (cand_q.size() == 0) begin
          check("unexpected_query", 64'(chk_t), 64'h1_FFFF_FFFF);
          failures += (chk_t == 33'h1_FFFF_FFFF) ? 1 : 0;
        end else begin
          c = cand_q.pop_front();
          check("chk_t", 64'(chk_t), 64'(c.t));
          aborted = 1'b0;
          for (int i = 0; i < c.delay; i++) begin
            @(negedge clk);
            if (rst_event) begin
              aborted = 1'b1;
              break;
            end
            check("chk_req_held", 64'(chk_req), 64'd1);
            check("chk_t_stable", 64'(chk_t), 64'(c.t));
          end
          if (!aborted) begin
            chk_ack     = 1'b1;
            chk_collide = c.collide;
            @(negedge clk);
            chk_ack     = 1'b0;
            chk_collide = 1'b0;
            check("chk_req_drop", 64'(chk_req), 64'd0);
          end
        end
      end
    end
  end

  // Done monitor: every done pulse must match the oldest expected result.
  initial begin : done_monitor
    exp_done_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = done_q.pop_front();
          check("t_out", 64'(t_out), 64'(e.t));
          check("success", 64'(success), 64'(e.success));
          check("busy_at_done", 64'(busy), 64'd0);
          check("done_cycle", 64'(cyc), 64'(e.cycle));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    exp_done_t e;
    rst   = 1'b1;
    start = 1'b0;
    dir   = 2'b00;
    t_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_chk_req", 64'(chk_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_success", 64'(success), 64'd0);
    check("rst_t_out", 64'(t_out), 64'd0);
    check("rst_chk_t", 64'(chk_t), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T CW, first candidate fits.
    add_cand(mk(TETROMINO_T, 2'd1, 5, 5, D_T), 1'b0, 0);
    run_op("t_cw", mk(TETROMINO_T, 2'd0, 5, 5, D_T), 2'b00, mk(TETROMINO_T, 2'd1, 5, 5, D_T), 1'b1, 3);

    // T CCW, kicks 0 and 1 collide, kick 2 (+1,-1) fits.
    add_cand(mk(TETROMINO_T, 2'd3, 5, 5, D_T), 1'b1, 0);
    add_cand(mk(TETROMINO_T, 2'd3, 6, 5, D_T), 1'b1, 0);
    add_cand(mk(TETROMINO_T, 2'd3, 6, 4, D_T), 1'b0, 0);
    run_op("t_ccw_k2", mk(TETROMINO_T, 2'd0, 5, 5, D_T), 2'b01, mk(TETROMINO_T, 2'd3, 6, 4, D_T), 1'b1, 7);

    // I rot 3 CW, all five kicks collide.
    add_cand(mk(TETROMINO_I, 2'd0, 4, 10, D_I), 1'b1, 0);
    add_cand(mk(TETROMINO_I, 2'd0, 5, 10, D_I), 1'b1, 0);
    add_cand(mk(TETROMINO_I, 2'd0, 2, 10, D_I), 1'b1, 0);
    add_cand(mk(TETROMINO_I, 2'd0, 5, 12, D_I), 1'b1, 0);
    add_cand(mk(TETROMINO_I, 2'd0, 2, 9, D_I), 1'b1, 0);
    run_op("i_all_fail", mk(TETROMINO_I, 2'd3, 4, 10, D_I), 2'b00, mk(TETROMINO_I, 2'd3, 4, 10, D_I), 1'b0, 11);

    // O rot 3 CW wraps to 0 without a query.
    run_op("o_cw", mk(TETROMINO_O, 2'd3, 3, 3, D_O), 2'b00, mk(TETROMINO_O, 2'd0, 3, 3, D_O), 1'b1, 2);

    // Z at x=0 CW, kick 1 (-1,0) goes negative.
    add_cand(mk(TETROMINO_Z, 2'd1, 0, 0, D_Z), 1'b1, 0);
    add_cand(mk(TETROMINO_Z, 2'd1, -1, 0, D_Z), 1'b0, 0);
    run_op("z_negx", mk(TETROMINO_Z, 2'd0, 0, 0, D_Z), 2'b00, mk(TETROMINO_Z, 2'd1, -1, 0, D_Z), 1'b1, 5);

    // Reserved direction rejected.
    run_op("dir_rsvd", mk(TETROMINO_L, 2'd1, 2, 2, D_L), 2'b11, mk(TETROMINO_L, 2'd1, 2, 2, D_L), 1'b0, 2);

    // 180 on T rot 1.
`ifdef ROT_180_EN
    add_cand(mk(TETROMINO_T, 2'd3, 5, 5, D_T), 1'b0, 0);
    run_op("t_180", mk(TETROMINO_T, 2'd1, 5, 5, D_T), 2'b10, mk(TETROMINO_T, 2'd3, 5, 5, D_T), 1'b1, 3);
`else
    run_op("t_180", mk(TETROMINO_T, 2'd1, 5, 5, D_T), 2'b10, mk(TETROMINO_T, 2'd1, 5, 5, D_T), 1'b0, 2);
`endif

    // Checker answers after 4 cycles; a second start while busy is ignored.
    add_cand(mk(TETROMINO_J, 2'd3, 7, 8, D_J), 1'b0, 4);
    @(negedge clk);
    e.t       = mk(TETROMINO_J, 2'd3, 7, 8, D_J);
    e.success = 1'b1;
    e.cycle   = cyc + 7;
    done_q.push_back(e);
    t_in  = mk(TETROMINO_J, 2'd2, 7, 8, D_J);
    dir   = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_mid", 64'(busy), 64'd1);
    t_in  = mk(TETROMINO_S, 2'd0, 1, 1, D_S);
    dir   = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("j_delay");

    // Reset while waiting on the checker: no done, handshake dropped.
    add_cand(mk(TETROMINO_S, 2'd1, 5, 5, D_S), 1'b0, 20);
    @(negedge clk);
    t_in  = mk(TETROMINO_S, 2'd0, 5, 5, D_S);
    dir   = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!chk_req && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_req_seen", 64'(chk_req), 64'd1);
    repeat (2) @(negedge clk);
    rst_event = 1'b1;
    rst       = 1'b1;
    #1;
    check("rst_mid_chk_req", 64'(chk_req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_mid_no_done", 64'(done), 64'd0);
    check("rst_mid_t_out", 64'(t_out), 64'd0);
    rst_event = 1'b0;
    cand_q.delete();

    // Recovery after reset: kick counter starts from entry 0 again.
    add_cand(mk(TETROMINO_L, 2'd1, 3, 6, D_L), 1'b1, 1);
    add_cand(mk(TETROMINO_L, 2'd1, 2, 6, D_L), 1'b0, 0);
    run_op("l_after_rst", mk(TETROMINO_L, 2'd0, 3, 6, D_L), 2'b00, mk(TETROMINO_L, 2'd1, 2, 6, D_L), 1'b1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
